// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
// Ports: none (package). Defines the KPG carry symbol and its combine rule.
// It also defines the function that assigns each prefix level to a pipeline stage.
package prefix_adder_pkg;

   // Carry-status symbol for one bit or one span of bits.
   typedef enum logic [1:0] {
      KPG_K = 2'b00,   // kill: carry out is 0 whatever comes in
      KPG_G = 2'b01,   // generate: carry out is 1 whatever comes in
      KPG_P = 2'b10    // propagate: carry out equals carry in
   } kpg_t;

   // Combine a higher-order span (upper) with the span directly below it (lower).
   // A propagating upper span defers to whatever the lower span resolves to.
   function automatic kpg_t kpg_combine(input kpg_t upper, input kpg_t lower);
      return (upper == KPG_P) ? lower : upper;
   endfunction

   // Per-bit symbol from the two operand bits.
   function automatic kpg_t kpg_form(input logic x, input logic y);
      kpg_t sym;
      if (x & y)
         sym = KPG_G;
      else if (x ^ y)
         sym = KPG_P;
      else
         sym = KPG_K;
      return sym;
   endfunction

   // Pipeline stage that evaluates prefix level `level` (0..levels-1).
   // Level `levels` stands for the sum/flag logic in front of the output registers.
   // That pseudo-level always maps to stage `stages`-1.
   // Because stages <= levels+1, consecutive levels differ by at most one stage.
   // So every register boundary falls between two levels, and none is ever skipped.
   function automatic int level_stage(input int level, input int levels, input int stages);
      return (level * stages) / (levels + 1);
   endfunction

endpackage

// File: rtl/prefix_adder_kpg_cell.sv
// One Kogge-Stone prefix node: merges a span with the span just below it.
// Ports: upper (higher-order span symbol), lower (lower-order span symbol), result.
// Purely combinational; zero latency, no flow control.
module kpg_cell
   import prefix_adder_pkg::*;
(
   input  kpg_t upper,
   input  kpg_t lower,
   output kpg_t result
);

   assign result = kpg_combine(upper, lower);

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined add/subtract unit built on a Kogge-Stone parallel-prefix carry tree.
// Ports: clk, rst_n; in_valid/in_ready with a, b, cin, sub; out_valid/out_ready with sum, cout, ovf, zero.
// Latency is STAGES cycles. The whole pipe stalls when the output is held (in_ready = out_ready | ~out_valid).
module prefix_adder_pipe
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int LEVELS = $clog2(WIDTH);

   // One global advance: a held result freezes every stage behind it.
   logic adv;
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Subtraction is a + ~b + 1; the +1 arrives through the carry-in position.
   logic [WIDTH-1:0] b_eff;
   assign b_eff = b ^ {WIDTH{sub}};

   // Node 0 is the carry-in (position -1), and node i+1 is operand bit i.
   // sym_in[k] is what enters prefix level k, and sym_in[LEVELS] feeds the sum logic.
   // hs_in and vld_in carry the half-sum bits and the beat valid along the same path.
   kpg_t             sym_in  [0:LEVELS][0:WIDTH];
   kpg_t             sym_out [0:LEVELS-1][0:WIDTH];
   logic [WIDTH-1:0] hs_in   [0:LEVELS];
   logic             vld_in  [0:LEVELS];

   assign sym_in[0][0] = (sub | cin) ? KPG_G : KPG_K;
   for (genvar j = 0; j < WIDTH; j++) begin : g_form
      assign sym_in[0][j+1] = kpg_form(a[j], b_eff[j]);
   end
   assign hs_in[0]  = a ^ b_eff;
   assign vld_in[0] = in_valid;

   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int DIST = 1 << k;

      // Each node j looks DIST positions down.
      // Nodes that have nothing below them at this distance are already complete.
      for (genvar j = 0; j <= WIDTH; j++) begin : g_node
         if (j >= DIST) begin : g_cell
            kpg_cell u_cell (
               .upper  (sym_in[k][j]),
               .lower  (sym_in[k][j-DIST]),
               .result (sym_out[k][j])
            );
         end else begin : g_pass
            assign sym_out[k][j] = sym_in[k][j];
         end
      end

      // A register boundary sits after this level when the next level belongs to a later stage.
      if (level_stage(k + 1, LEVELS, STAGES) != level_stage(k, LEVELS, STAGES)) begin : g_reg
         kpg_t             sym_q [0:WIDTH];
         logic [WIDTH-1:0] hs_q;
         logic             vld_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= 1'b0;
               hs_q  <= '0;
               for (int n = 0; n <= WIDTH; n++) begin
                  sym_q[n] <= KPG_K;
               end
            end else if (adv) begin
               vld_q <= vld_in[k];
               hs_q  <= hs_in[k];
               for (int n = 0; n <= WIDTH; n++) begin
                  sym_q[n] <= sym_out[k][n];
               end
            end
         end

         assign vld_in[k+1] = vld_q;
         assign hs_in[k+1]  = hs_q;
         for (genvar j = 0; j <= WIDTH; j++) begin : g_conn
            assign sym_in[k+1][j] = sym_q[j];
         end
      end else begin : g_wire
         assign vld_in[k+1] = vld_in[k];
         assign hs_in[k+1]  = hs_in[k];
         for (genvar j = 0; j <= WIDTH; j++) begin : g_conn
            assign sym_in[k+1][j] = sym_out[k][j];
         end
      end
   end

   // Resolved carries: c[i] is the carry into bit i.
   // Nodes 0..WIDTH-1 reach all the way down to the carry-in, so none of them is left as P.
   // Node WIDTH only spans bits 0..WIDTH-1, so one last merge with the carry-in completes cout.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   kpg_t             top_sym;

   for (genvar j = 0; j < WIDTH; j++) begin : g_carry
      assign carry[j] = (sym_in[LEVELS][j] == KPG_G);
   end
   assign top_sym      = kpg_combine(sym_in[LEVELS][WIDTH], sym_in[LEVELS][0]);
   assign carry[WIDTH] = (top_sym == KPG_G);
   assign sum_d        = hs_in[LEVELS] ^ carry[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (adv) begin
         out_valid <= vld_in[LEVELS];
         sum       <= sum_d;
         cout      <= carry[WIDTH];
         ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
         zero      <= (sum_d == '0);
      end
   end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe.
// Main instance: WIDTH=32, STAGES=2. Second instance: WIDTH=8, STAGES=4 (maximum depth).
// Expected results come from a plain-arithmetic reference model and an in-order scoreboard.
module tb_prefix_adder_pipe;

   localparam int W  = 32;
   localparam int S  = 2;
   localparam int W2 = 8;
   localparam int S2 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
   logic [W-1:0]  a, b, sum;
   logic          alt_in_valid, alt_in_ready, alt_cin, alt_sub, alt_out_valid, alt_out_ready;
   logic          alt_cout, alt_ovf, alt_zero;
   logic [W2-1:0] alt_a, alt_b, alt_sum;

   int n_vec = 0;
   int n_bad = 0;

   prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   prefix_adder_pipe #(.WIDTH(W2), .STAGES(S2)) dut_alt (
      .clk(clk), .rst_n(rst_n), .in_valid(alt_in_valid), .in_ready(alt_in_ready),
      .a(alt_a), .b(alt_b), .cin(alt_cin), .sub(alt_sub), .out_valid(alt_out_valid),
      .out_ready(alt_out_ready), .sum(alt_sum), .cout(alt_cout), .ovf(alt_ovf), .zero(alt_zero)
   );

   // Reference: integer add/subtract, with flags derived from operand and result signs.
   task automatic ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                          input logic c, input logic s,
                          output logic [66:0] res);
      logic [127:0] full, mask;
      logic [63:0]  r;
      logic         co, ov, z;
      mask = (128'd1 << w) - 128'd1;
      if (s) begin
         full = {64'd0, x} - {64'd0, y};
         co   = (x >= y);
      end else begin
         full = {64'd0, x} + {64'd0, y} + {127'd0, c};
         co   = full[w];
      end
      r = 64'(full & mask);
      if (s) ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      else   ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      z   = (r == 64'd0);
      res = {ov, z, co, r};
   endtask

   function automatic logic [63:0] rnd_operand(input int w);
      logic [63:0] v, mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(7))
         0:       v = '0;
         1:       v = '1;
         2:       v = 64'd1 << (w - 1);
         3:       v = (64'd1 << (w - 1)) - 64'd1;
         default: v = {$urandom, $urandom};
      endcase
      return v & mask;
   endfunction

   // All tasks below start and end one time unit after a rising edge.
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
      alt_in_valid = 0; alt_a = '0; alt_b = '0; alt_cin = 0; alt_sub = 0; alt_out_ready = 1;
      #2 rst_n = 1'b0;
      #3;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_vec++; if (sum !== '0) begin n_bad++; $display("FAIL reset_sum got=%h want=0", sum); end
      n_vec++; if ({cout, ovf, zero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {cout, ovf, zero}); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      n_vec++; if (alt_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_alt_out_valid got=%b want=0", alt_out_valid); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0] x, y;
      logic        c, s;
      logic [31:0] r;
      logic        co, ov, z;
   } vec_t;

   task automatic test_directed();
      vec_t tbl [10] = '{
         '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
         '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
         '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
         '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
         '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
         '{32'h0000_000A, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_001F, 1'b0, 1'b0, 1'b0},
         '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
         '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1},
         '{32'h0000_04D2, 32'h0000_04D2, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
         '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}
      };
      int lat;
      for (int t = 0; t < 10; t++) begin
         idle(2);
         out_ready = 1; in_valid = 1; a = tbl[t].x; b = tbl[t].y; cin = tbl[t].c; sub = tbl[t].s;
         lat = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 0;
            lat++;
            if (out_valid) break;
         end
         n_vec++;
         if (lat != S) begin
            n_bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", t, lat, S);
         end
         n_vec++;
         if ({sum, cout, ovf, zero} !== {tbl[t].r, tbl[t].co, tbl[t].ov, tbl[t].z}) begin
            n_bad++;
            $display("FAIL dir%0d_result got sum=%h c/o/z=%b%b%b want sum=%h c/o/z=%b%b%b",
                     t, sum, cout, ovf, zero, tbl[t].r, tbl[t].co, tbl[t].ov, tbl[t].z);
         end
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic         rv [8];
      logic [W-1:0] rs [8];
      int           nv;
      out_ready = 1; in_valid = 1; a = 32'd1; b = 32'd1; cin = 0; sub = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c < 2) begin a = W'(c + 2); b = W'(c + 2); end
         else in_valid = 0;
         rv[c] = out_valid;
         rs[c] = sum;
      end
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (rv[S-1+k] !== 1'b1 || rs[S-1+k] !== W'(2 * (k + 1))) begin
            n_bad++;
            $display("FAIL b2b_beat%0d got vld=%b sum=%h want vld=1 sum=%h",
                     k, rv[S-1+k], rs[S-1+k], W'(2 * (k + 1)));
         end
      end
      nv = 0;
      for (int c = 0; c < 8; c++) nv += int'(rv[c]);
      n_vec++; if (nv != 3) begin n_bad++; $display("FAIL b2b_valid_count got=%0d want=3", nv); end
      idle(2);
   endtask

   task automatic test_backpressure();
      logic [66:0] q [$];
      logic [66:0] e, act, held;
      int          sent, got, stall, extra;
      bit          seen;
      sent = 0; got = 0; stall = 0; seen = 0; extra = 0; held = '0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         in_valid = (sent < 6);
         a = 32'(sent) * 32'h0101_0101 + 32'd1; b = 32'hFFFF_0000 + 32'(sent); cin = sent[0]; sub = sent[1];
         out_ready = 1;
         if (out_valid && !seen) begin
            seen = 1; stall = 4; held = {ovf, zero, cout, 32'd0, sum};
         end
         if (stall > 0) out_ready = 0;
         @(negedge clk);
         if (stall > 0) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
            if (stall < 4) begin
               n_vec++;
               act = {ovf, zero, cout, 32'd0, sum};
               if (out_valid !== 1'b1 || act !== held) begin
                  n_bad++; $display("FAIL bp_frozen got vld=%b out=%h want vld=1 out=%h", out_valid, act, held);
               end
            end
            stall--;
         end
         if (in_valid && in_ready) begin
            ref_add(W, 64'(a), 64'(b), cin, sub, e); q.push_back(e); sent++;
         end
         if (out_valid && out_ready) begin
            act = {ovf, zero, cout, 32'd0, sum};
            n_vec++;
            if (q.size() == 0) begin
               n_bad++; $display("FAIL bp_extra_result got=%h want=none", act);
            end else begin
               e = q.pop_front();
               if (act !== e) begin n_bad++; $display("FAIL bp_result%0d got=%h want=%h", got, act, e); end
            end
            got++;
         end
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      n_vec++; if (got != 6) begin n_bad++; $display("FAIL bp_count got=%0d want=6", got); end
      repeat (S + 3) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_vec++; if (extra != 0) begin n_bad++; $display("FAIL bp_duplicate got=%0d want=0", extra); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      int stale, lat;
      out_ready = 1; cin = 0; sub = 0;
      in_valid = 1; a = 32'd11; b = 32'd22;
      @(posedge clk); #1;
      a = 32'd33; b = 32'd44;
      @(posedge clk); #2;
      in_valid = 0;
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
      n_vec++; if ({sum, cout, ovf, zero} !== '0) begin n_bad++; $display("FAIL rst_mid_outputs got=%h want=0", {sum, cout, ovf, zero}); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      stale = 0;
      repeat (S + 3) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      n_vec++; if (stale != 0) begin n_bad++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
      in_valid = 1; a = 32'd100; b = 32'd23; cin = 1; sub = 0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         in_valid = 0;
         lat++;
         if (out_valid) break;
      end
      n_vec++;
      if (lat != S || sum !== 32'd124) begin
         n_bad++; $display("FAIL rst_first_beat got lat=%0d sum=%h want lat=%0d sum=%h", lat, sum, S, 32'd124);
      end
      idle(2);
   endtask

   task automatic test_random();
      logic [66:0] q [$];
      logic [66:0] q2 [$];
      logic [66:0] e, act;
      int          nres, nres2;
      nres = 0; nres2 = 0;
      for (int cyc = 0; cyc < 4030; cyc++) begin
         if (cyc < 4000) begin
            in_valid = ($urandom_range(3) != 0);
            a = W'(rnd_operand(W)); b = W'(rnd_operand(W));
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            alt_in_valid = ($urandom_range(3) != 0);
            alt_a = W2'(rnd_operand(W2)); alt_b = W2'(rnd_operand(W2));
            alt_cin = 1'($urandom_range(1)); alt_sub = 1'($urandom_range(1));
            alt_out_ready = ($urandom_range(2) != 0);
         end else begin
            in_valid = 0; out_ready = 1; alt_in_valid = 0; alt_out_ready = 1;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            ref_add(W, 64'(a), 64'(b), cin, sub, e); q.push_back(e);
         end
         if (alt_in_valid && alt_in_ready) begin
            ref_add(W2, 64'(alt_a), 64'(alt_b), alt_cin, alt_sub, e); q2.push_back(e);
         end
         if (out_valid && out_ready) begin
            act = {ovf, zero, cout, 32'd0, sum};
            n_vec++;
            if (q.size() == 0) begin
               n_bad++; $display("FAIL rnd32_extra got=%h want=none", act);
            end else begin
               e = q.pop_front();
               if (act !== e) begin n_bad++; $display("FAIL rnd32_result%0d got=%h want=%h", nres, act, e); end
            end
            nres++;
         end
         if (alt_out_valid && alt_out_ready) begin
            act = {alt_ovf, alt_zero, alt_cout, 56'd0, alt_sum};
            n_vec++;
            if (q2.size() == 0) begin
               n_bad++; $display("FAIL rnd8_extra got=%h want=none", act);
            end else begin
               e = q2.pop_front();
               if (act !== e) begin n_bad++; $display("FAIL rnd8_result%0d got=%h want=%h", nres2, act, e); end
            end
            nres2++;
         end
         @(posedge clk); #1;
      end
      n_vec++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd32_lost got=%0d want=0", q.size()); end
      n_vec++; if (q2.size() != 0) begin n_bad++; $display("FAIL rnd8_lost got=%0d want=0", q2.size()); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=completion");
      $fatal(1, "bench did not complete");
   end

endmodule
